acker_valve_sched: RTL and testbench
====================================

# acker_valve_sched

Round-robin scheduler that shares the single outlet-valve PWM channel of the Ackerchip between several irrigation zones. It grants one zone at a time and drives the PWM `voltage`/`power` inputs through a soft-open ramp, a timed hold and a soft-close ramp. It signals completion per zone. It sits between the zone request logic and the PWM block.

## Interface
- `NUM_ZONES`, 4: number of requesting zones (2..8).
- `RAMP_STEP`, 8'd16: duty increment/decrement per tick.
- `RAMP_DIV`, 16'd256: clock cycles per tick (≥2).
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when low, no new grants are issued and an active cycle aborts to CLOSE.
- `req`  in  NUM_ZONES  level requests, one per zone.
- `target_duty`  in  8  hold duty, sampled at grant.
- `hold_time`  in  16  hold length in ticks, sampled at grant.
- `voltage`  out  8  duty to PWM.
- `power`  out  1  PWM power enable.
- `grant`  out  NUM_ZONES  one-hot valve select; all zero when idle.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  NUM_ZONES  one-cycle pulse for the finished zone.

## Operation
- States are IDLE, OPEN, HOLD and CLOSE. All outputs are registered.
- **IDLE:** `voltage`=0, `power`=0, `grant`=0.
  - If `enable`=1 and any `req` is high, grant the first requesting zone at or after `last+1`, with wrap-around.
  - On grant: latch `target_duty`/`hold_time`, clear the prescaler, go to OPEN.
  - `last` resets to NUM_ZONES-1, so zone 0 has first priority.
- **OPEN:** on each tick, `voltage` = min(`voltage`+RAMP_STEP, target). Use 9-bit arithmetic and saturate at 255.
  - On the tick where `voltage` equals target, go to HOLD and load the hold counter.
  - When target is 0, that is the first tick.
- **HOLD:** `voltage` is held.
  - On each tick: if counter ≤1, go to CLOSE; otherwise decrement.
  - HOLD therefore lasts max(`hold_time`,1) ticks.
- **CLOSE:** on each tick, `voltage` = max(`voltage`-RAMP_STEP, 0).
  - On the tick where the result is 0, go to IDLE.
  - On that transition, clear `grant`, drop `power` and pulse `done[z]`. All three occur in the first IDLE cycle. Set `last`=z.
- **Abort:** if `req[z]`=0 or `enable`=0 in OPEN or HOLD, go to CLOSE on the next edge. Ramp-down starts from the current `voltage`.
  - Requests dropped during CLOSE are ignored.
- `power`=1 and `grant`=one-hot in OPEN, HOLD and CLOSE.
- Requests from other zones never pre-empt an active cycle.
- `grant` never changes outside the IDLE transitions.
- **Async reset:** takes effect at any time, including mid-ramp. State goes to IDLE and all outputs go to 0 immediately. The prescaler and hold counter clear, and `last` goes to NUM_ZONES-1.

## Timing
- Grant latency is 1 cycle: `req` is sampled at edge N, and `grant`/`power`/`busy` are high after edge N.
- Ticks occur RAMP_DIV, 2·RAMP_DIV, … cycles after entry to OPEN.
- The prescaler runs free through OPEN, HOLD and CLOSE. It is not re-phased on state changes or aborts.
- Full ramp 0→255 at step 16 takes 16 ticks, with saturation on the 16th.
- There is at least 1 IDLE cycle between consecutive grants, because a re-grant is evaluated in the cycle that `done` is high.
- The zone just completed has the lowest priority in that arbitration.

## Structure
- The shared package `acker_pkg` holds:
  - the state enum (IDLE/OPEN/HOLD/CLOSE);
  - default RAMP_STEP/RAMP_DIV constants;
  - the ZONE_MAX=8 bound.
- One sub-module: `acker_tick_gen`. It is a prescaler with a clear input and a one-cycle `tick` output at count RAMP_DIV-1, wrapping to 0.
- The round-robin arbiter is combinational inside the top level; it is not a separate module.

## Test plan
Bench parameters: RAMP_DIV=4, RAMP_STEP=16, NUM_ZONES=4.

- **Basic cycle:** `req`=0001, target=64, hold=2 →
  - `grant`=0001 one cycle later;
  - `voltage` 16/32/48/64 at ticks 1–4;
  - HOLD for 2 ticks;
  - `voltage` 48/32/16/0;
  - `done[0]` pulses for one cycle and `grant` returns to 0.
- **Saturation:** target=255 → 16 OPEN ticks, `voltage` 240 then 255, never wraps. Target=0, hold=0 → HOLD for 1 tick, then IDLE on the first CLOSE tick.
- **Round-robin:** `req`=1111 held → grants in order 0001, 0010, 0100, 1000, 0001, with ≥1 IDLE cycle between each.
- **Abort:** `req[0]` drops in HOLD at `voltage`=64 → CLOSE next edge, ramp 48→0, then `done[0]`. `enable`=0 in OPEN behaves the same. `enable`=0 in IDLE with `req`=1111 → no grant.
- **Mid-ramp reset:** assert `reset`=0 asynchronously between edges during OPEN → `voltage`/`power`/`grant`/`busy` are 0 before the next edge. After release, zone 0 has priority.
- **Input stability:** change `target_duty` and `hold_time` during HOLD → no effect on the active cycle.

Source files
------------

// File: rtl/acker_pkg.sv
// Shared types and constants for the Ackerchip valve scheduler.
// Holds the FSM state encoding, default ramp settings and zone bound.
package acker_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    HOLD,
    CLOSE
  } state_t;

  localparam logic [7:0]  RAMP_STEP_DEF = 8'd16;
  localparam logic [15:0] RAMP_DIV_DEF  = 16'd256;

  localparam int ZONE_MAX = 8;
  localparam int ZW       = $clog2(ZONE_MAX);

endpackage

// File: rtl/acker_tick_gen.sv
// Ramp prescaler: one-cycle tick every RAMP_DIV clocks.
// Clear holds the count at zero so the first tick lands RAMP_DIV after release.
module acker_tick_gen
  import acker_pkg::*;
#(
  parameter logic [15:0] RAMP_DIV = RAMP_DIV_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  logic [15:0] cnt;
  logic        wrap;

  assign wrap = (cnt == RAMP_DIV - 16'd1);
  assign tick = wrap && !clear;

  // free-running count, wraps at RAMP_DIV-1
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/acker_valve_sched.sv
// Round-robin owner of the outlet-valve PWM channel.
// Grants one zone at a time through open ramp, hold and close ramp.
module acker_valve_sched
  import acker_pkg::*;
#(
  parameter int          NUM_ZONES = 4,
  parameter logic [7:0]  RAMP_STEP = RAMP_STEP_DEF,
  parameter logic [15:0] RAMP_DIV  = RAMP_DIV_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_ZONES-1:0] req,
  input  logic [7:0]           target_duty,
  input  logic [15:0]          hold_time,
  output logic [7:0]           voltage,
  output logic                 power,
  output logic [NUM_ZONES-1:0] grant,
  output logic                 busy,
  output logic [NUM_ZONES-1:0] done
);

  state_t                 state, state_n;
  logic [7:0]             voltage_n;
  logic                   power_n;
  logic [NUM_ZONES-1:0]   grant_n;
  logic                   busy_n;
  logic [NUM_ZONES-1:0]   done_n;
  logic [ZW-1:0]          last, last_n;
  logic [ZW-1:0]          zone, zone_n;
  logic [7:0]             target, target_n;
  logic [15:0]            hold_cnt, hold_n;

  logic                   tick;
  logic [ZONE_MAX-1:0]    req_w;
  logic                   found;
  logic [ZW-1:0]          pick;
  logic                   abort;
  logic [8:0]             up_sum;
  logic [7:0]             up_sat;
  logic [7:0]             up_v;
  logic [7:0]             dn_v;

  acker_tick_gen #(
    .RAMP_DIV (RAMP_DIV)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .clear (state == IDLE),
    .tick  (tick)
  );

  assign req_w = ZONE_MAX'(req);
  assign abort = !enable || !req_w[zone];

  assign up_sum = {1'b0, voltage} + {1'b0, RAMP_STEP};
  assign up_sat = up_sum[8] ? 8'hFF : up_sum[7:0];
  assign up_v   = (up_sat > target) ? target : up_sat;
  assign dn_v   = (voltage > RAMP_STEP) ? voltage - RAMP_STEP : 8'd0;

  // round-robin pick: first request after last, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= NUM_ZONES; i++) begin
      logic [ZW-1:0] k;
      k = ZW'((int'(last) + i) % NUM_ZONES);
      if (!found && req_w[k]) begin
        found = 1'b1;
        pick  = k;
      end
    end
  end

  // next state and next registered outputs
  always_comb begin
    state_n   = state;
    voltage_n = voltage;
    power_n   = power;
    grant_n   = grant;
    busy_n    = busy;
    done_n    = '0;
    last_n    = last;
    zone_n    = zone;
    target_n  = target;
    hold_n    = hold_cnt;
    unique case (state)
      IDLE: begin
        if (enable && found) begin
          state_n   = OPEN;
          voltage_n = 8'd0;
          power_n   = 1'b1;
          busy_n    = 1'b1;
          grant_n   = NUM_ZONES'(1) << pick;
          zone_n    = pick;
          target_n  = target_duty;
          hold_n    = hold_time;
        end
      end
      OPEN: begin
        if (abort) begin
          state_n = CLOSE;
        end else if (tick) begin
          voltage_n = up_v;
          if (up_v == target) begin
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (abort) begin
          state_n = CLOSE;
        end else if (tick) begin
          if (hold_cnt <= 16'd1) begin
            state_n = CLOSE;
          end else begin
            hold_n = hold_cnt - 16'd1;
          end
        end
      end
      CLOSE: begin
        if (tick) begin
          voltage_n = dn_v;
          if (dn_v == 8'd0) begin
            state_n = IDLE;
            power_n = 1'b0;
            busy_n  = 1'b0;
            grant_n = '0;
            done_n  = grant;
            last_n  = zone;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      voltage  <= '0;
      power    <= 1'b0;
      grant    <= '0;
      busy     <= 1'b0;
      done     <= '0;
      last     <= ZW'(NUM_ZONES - 1);
      zone     <= '0;
      target   <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      voltage  <= voltage_n;
      power    <= power_n;
      grant    <= grant_n;
      busy     <= busy_n;
      done     <= done_n;
      last     <= last_n;
      zone     <= zone_n;
      target   <= target_n;
      hold_cnt <= hold_n;
    end
  end

endmodule

// File: tb/tb_acker_valve_sched.sv
// Directed bench for acker_valve_sched.
// Vector table of full cycles plus hand sequences for abort and reset.
module tb_acker_valve_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  req = '0;
  logic [7:0]  target_duty = '0;
  logic [15:0] hold_time = '0;
  logic [7:0]  voltage;
  logic        power;
  logic [3:0]  grant;
  logic        busy;
  logic [3:0]  done;

  always #5 clock = ~clock;

  acker_valve_sched #(
    .NUM_ZONES (4),
    .RAMP_STEP (8'd16),
    .RAMP_DIV  (16'd4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .req         (req),
    .target_duty (target_duty),
    .hold_time   (hold_time),
    .voltage     (voltage),
    .power       (power),
    .grant       (grant),
    .busy        (busy),
    .done        (done)
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [3:0]  rq;
    logic [7:0]  tgt;
    logic [15:0] hld;
    logic [3:0]  gnt;
    int          peak;
    int          cyc;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int n;
    int m;
    int pk;
    int v2;

    tbl[0] = '{4'b0001, 8'd64,  16'd2, 4'b0001, 64,  40};
    tbl[1] = '{4'b0001, 8'd255, 16'd1, 4'b0001, 255, 132};
    tbl[2] = '{4'b0001, 8'd0,   16'd0, 4'b0001, 0,   12};
    tbl[3] = '{4'b1111, 8'd100, 16'd3, 4'b0010, 100, 68};
    tbl[4] = '{4'b1111, 8'd32,  16'd1, 4'b0100, 32,  20};
    tbl[5] = '{4'b1111, 8'd16,  16'd1, 4'b1000, 16,  12};
    tbl[6] = '{4'b1111, 8'd48,  16'd2, 4'b0001, 48,  32};
    tbl[7] = '{4'b1010, 8'd16,  16'd1, 4'b0010, 16,  12};
    tbl[8] = '{4'b0010, 8'd16,  16'd1, 4'b0010, 16,  12};

    #12;
    chk("rst_voltage", int'(voltage), 0);
    chk("rst_power", int'(power), 0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      enable      = 1'b1;
      req         = tbl[i].rq;
      target_duty = tbl[i].tgt;
      hold_time   = tbl[i].hld;
      step();
      chk($sformatf("v%0d_grant", i), int'(grant), int'(tbl[i].gnt));
      chk($sformatf("v%0d_power", i), int'(power), 1);
      chk($sformatf("v%0d_busy", i), int'(busy), 1);
      if (i > 0) chk($sformatf("v%0d_done_pulse", i), int'(done), 0);
      n  = 0;
      pk = 0;
      while (done == 4'b0000 && n < 1000) begin
        step();
        n++;
        if (int'(voltage) > pk) pk = int'(voltage);
        target_duty = 8'(n * 37);
        hold_time   = 16'(n * 3);
      end
      chk($sformatf("v%0d_cycles", i), n, tbl[i].cyc);
      chk($sformatf("v%0d_done", i), int'(done), int'(tbl[i].gnt));
      chk($sformatf("v%0d_peak", i), pk, tbl[i].peak);
      chk($sformatf("v%0d_idle_grant", i), int'(grant), 0);
      chk($sformatf("v%0d_idle_busy", i), int'(busy), 0);
      chk($sformatf("v%0d_idle_power", i), int'(power), 0);
      req = '0;
    end

    enable = 1'b0;
    req    = 4'b1111;
    repeat (6) step();
    chk("dis_grant", int'(grant), 0);
    chk("dis_busy", int'(busy), 0);

    enable      = 1'b1;
    req         = 4'b0001;
    target_duty = 8'd64;
    hold_time   = 16'd10;
    step();
    chk("ab_grant", int'(grant), 1);
    n = 0;
    while (voltage != 8'd64 && n < 100) begin
      step();
      n++;
    end
    chk("ab_open_cycles", n, 16);
    step();
    step();
    chk("ab_hold_v", int'(voltage), 64);
    req = 4'b0000;
    m  = 0;
    v2 = -1;
    while (done == 4'b0000 && m < 100) begin
      step();
      m++;
      if (m == 2) v2 = int'(voltage);
    end
    chk("ab_first_down", v2, 48);
    chk("ab_cycles", m, 14);
    chk("ab_done", int'(done), 1);

    enable      = 1'b1;
    req         = 4'b0001;
    target_duty = 8'd64;
    hold_time   = 16'd2;
    step();
    chk("en_grant", int'(grant), 1);
    n = 0;
    while (voltage != 8'd32 && n < 100) begin
      step();
      n++;
    end
    chk("en_open_cycles", n, 8);
    enable = 1'b0;
    m  = 0;
    v2 = -1;
    while (done == 4'b0000 && m < 100) begin
      step();
      m++;
      if (m == 4) v2 = int'(voltage);
    end
    chk("en_first_down", v2, 16);
    chk("en_cycles", m, 8);
    chk("en_done", int'(done), 1);

    enable = 1'b1;
    req    = 4'b1111;
    step();
    chk("rs_grant", int'(grant), 2);
    n = 0;
    while (voltage != 8'd32 && n < 100) begin
      step();
      n++;
    end
    chk("rs_open_cycles", n, 8);
    #3;
    reset = 1'b0;
    #1;
    chk("rs_voltage", int'(voltage), 0);
    chk("rs_power", int'(power), 0);
    chk("rs_grant0", int'(grant), 0);
    chk("rs_busy", int'(busy), 0);
    #2;
    reset = 1'b1;
    step();
    chk("rs_prio", int'(grant), 1);
    req = 4'b0000;
    m = 0;
    while (done == 4'b0000 && m < 200) begin
      step();
      m++;
    end
    chk("rs_done", int'(done), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
